// File: rtl/aes_subbytes_seq.sv
// aes_subbytes_seq: iterative AES SubBytes engine, LANES shared S-boxes per cycle.
// Optional inverse S-box support is enabled with `define AES_SUBBYTES_INV_EN.

package aes_gf_pkg;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction
endpackage

module aes_Sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] aes128_sbox
);
  logic [7:0] t;
  assign t = aes_gf_pkg::gf_inv(sbox_in);
  assign aes128_sbox = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
                     ^ {t[3:0], t[7:4]} ^ 8'h63;
endmodule

`ifdef AES_SUBBYTES_INV_EN
module aes_inv_Sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] aes128_inv_sbox
);
  logic [7:0] a;
  // undo the affine step first, then invert in the field
  assign a = {sbox_in[6:0], sbox_in[7]} ^ {sbox_in[4:0], sbox_in[7:5]}
           ^ {sbox_in[1:0], sbox_in[7:2]} ^ 8'h05;
  assign aes128_inv_sbox = aes_gf_pkg::gf_inv(a);
endmodule
`endif

// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | substituting LANES bytes per cycle
// DONE  | result presented with out_valid until out_ready
module aes_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [15:0][7:0] data_q;   // data_q[15] is byte 0
  logic             accept;
  logic [7:0]       lane_in  [LANES];
  logic [7:0]       lane_out [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          accept  = in_valid;
          state_d = in_valid ? BUSY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // counter saturates at LAST so it never wraps inside a block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt_q <= '0;
    else if (accept)                           cnt_q <= '0;
    else if (state_q == BUSY && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[15 - l];
      for (int s = 0; s < STEPS; s++) begin
        if (cnt_q == CW'(s)) lane_in[l] = data_q[15 - (s * LANES + l)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= state_in;
    end else if (state_q == BUSY) begin
      for (int b = 0; b < 16; b++) begin
        if (cnt_q == CW'(b / LANES)) data_q[15 - b] <= lane_out[b % LANES];
      end
    end
  end

`ifdef AES_SUBBYTES_INV_EN
  logic mode_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mode_q <= 1'b0;
    else if (accept) mode_q <= inv_mode;
  end
`else
  logic unused_inv_mode;
  assign unused_inv_mode = inv_mode;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] fwd;
    aes_Sbox u_fwd (.sbox_in(lane_in[l]), .aes128_sbox(fwd));
`ifdef AES_SUBBYTES_INV_EN
    logic [7:0] inv;
    aes_inv_Sbox u_inv (.sbox_in(lane_in[l]), .aes128_inv_sbox(inv));
    assign lane_out[l] = mode_q ? inv : fwd;
`else
    assign lane_out[l] = fwd;
`endif
  end

  assign state_out = (state_q == DONE) ? data_q : '0;
endmodule

// File: tb/tb_aes_subbytes_seq.sv
// tb_aes_subbytes_seq: five engines (LANES 1,2,4,8,16) on shared inputs, checked
// every cycle against a table-driven model plus literal AES vectors.
module tb_aes_subbytes_seq;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state_in;
  logic         inv_mode;
  logic         out_ready;
  logic [4:0]   in_ready_w;
  logic [4:0]   out_valid_w;
  logic [4:0]   busy_w;
  logic [4:0][127:0] state_out_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  int           busy_left [5];
  bit           have_out  [5];
  logic [127:0] exp_out   [5];

  localparam logic [127:0] VEC     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_EXP = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ZERO_EXP = {16{8'h63}};
  localparam logic [127:0] ED_IN   = {8'hed, {15{8'h63}}};
`ifdef AES_SUBBYTES_INV_EN
  localparam logic [127:0] ED_EXP  = {8'h53, {15{8'h00}}};
`else
  localparam logic [127:0] ED_EXP  = {8'h55, {15{8'hfb}}};
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_subbytes_seq #(.LANES(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready_w[g]),
      .state_in (state_in),
      .inv_mode (inv_mode),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready),
      .state_out(state_out_w[g]),
      .busy     (busy_w[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] subst(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   v;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      v = s[8*(15-b) +: 8];
`ifdef AES_SUBBYTES_INV_EN
      r[8*(15-b) +: 8] = inv ? isb[v] : sb[v];
`else
      r[8*(15-b) +: 8] = sb[v];
`endif
    end
    return r;
  endfunction

  // S-box built from the generator-3 walk of GF(2^8), independent of the RTL datapath
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
  endtask

  // Model: a block accepted at edge k is due STEPS edges later and held until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 5; g++) begin
        busy_left[g] <= 0;
        have_out[g]  <= 1'b0;
        exp_out[g]   <= '0;
      end
    end else begin
      for (int g = 0; g < 5; g++) begin
        int bl;
        bit ho, acc;
        bl  = busy_left[g];
        ho  = have_out[g];
        acc = in_valid && ((bl == 0 && !ho) || (ho && out_ready));
        if (ho && out_ready) ho = 1'b0;
        if (bl > 0) begin
          bl = bl - 1;
          if (bl == 0) ho = 1'b1;
        end
        if (acc) begin
          bl = 16 >> g;
          exp_out[g] <= subst(state_in, inv_mode);
        end
        busy_left[g] <= bl;
        have_out[g]  <= ho;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 5; g++) begin
      bit rdy;
      rdy = (busy_left[g] == 0) && (!have_out[g] || out_ready);
      chk($sformatf("out_valid L%0d", 1 << g), 128'(out_valid_w[g]), 128'(have_out[g]));
      chk($sformatf("busy L%0d", 1 << g), 128'(busy_w[g]), 128'(busy_left[g] > 0));
      chk($sformatf("in_ready L%0d", 1 << g), 128'(in_ready_w[g]), 128'(rdy));
      chk($sformatf("state_out L%0d", 1 << g), state_out_w[g], have_out[g] ? exp_out[g] : '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  // one block into all idle engines; each must finish after exactly 16/LANES edges
  task automatic run_block(input logic [127:0] vec, input logic inv, input logic [127:0] exp);
    chk("model vector", subst(vec, inv), exp);
    in_valid  = 1'b1;
    state_in  = vec;
    inv_mode  = inv;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    state_in = ~vec;
    for (int n = 1; n <= 16; n++) begin
      step();
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("latency L%0d n%0d", 1 << g, n), 128'(out_valid_w[g]), 128'(n == (16 >> g)));
        if (n == (16 >> g)) chk($sformatf("result L%0d", 1 << g), state_out_w[g], exp);
        if (n < (16 >> g))  chk($sformatf("ready in busy L%0d", 1 << g), 128'(in_ready_w[g]), 128'(0));
      end
    end
  endtask

  logic [127:0] blk [3];
  int           out_cyc [3];
  logic [127:0] out_val [3];
  int           idx, nout;
  bit           taking;

  initial begin
    build_tables();
    rst_n = 1'b0;
    in_valid = 1'b0;
    state_in = '0;
    inv_mode = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("reset in_ready", 128'(in_ready_w), 128'(5'h1f));
    chk("reset out_valid", 128'(out_valid_w), 128'(0));
    chk("reset busy", 128'(busy_w), 128'(0));
    for (int g = 0; g < 5; g++) chk($sformatf("reset state_out L%0d", 1 << g), state_out_w[g], '0);
    rst_n = 1'b1;
    drain(2);

    run_block(VEC, 1'b0, VEC_EXP);
    drain(2);
    run_block('0, 1'b0, ZERO_EXP);
    drain(2);
    run_block(ED_IN, 1'b1, ED_EXP);
    drain(2);

    // back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = VEC;
    inv_mode  = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (17) step();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      state_in = '0;
      step();
      chk("bp out_valid held", 128'(out_valid_w), 128'(5'h1f));
      chk("bp in_ready low", 128'(in_ready_w), 128'(0));
      for (int g = 0; g < 5; g++) chk($sformatf("bp held L%0d", 1 << g), state_out_w[g], VEC_EXP);
    end
    out_ready = 1'b1;
    #1;
    chk("bp same-cycle ready", 128'(in_ready_w), 128'(5'h1f));
    step();
    chk("bp accepted busy", 128'(busy_w), 128'(5'h1f));
    chk("bp accepted no valid", 128'(out_valid_w), 128'(0));
    drain(18);

    // back-to-back on LANES=8
    blk[0] = VEC;
    blk[1] = '0;
    blk[2] = ED_IN;
    idx = 0;
    nout = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    inv_mode = 1'b0;
    state_in = blk[0];
    for (int cyc = 0; cyc < 20; cyc++) begin
      taking = in_valid && in_ready_w[3];
      step();
      if (taking) begin
        idx++;
        if (idx < 3) state_in = blk[idx];
        else         in_valid = 1'b0;
      end
      if (out_valid_w[3] && nout < 3) begin
        out_cyc[nout] = cyc;
        out_val[nout] = state_out_w[3];
        nout++;
      end
    end
    chk("b2b outputs", 128'(nout), 128'(3));
    chk("b2b spacing 0-1", 128'(out_cyc[1] - out_cyc[0]), 128'(3));
    chk("b2b spacing 1-2", 128'(out_cyc[2] - out_cyc[1]), 128'(3));
    chk("b2b block 0", out_val[0], VEC_EXP);
    chk("b2b block 1", out_val[1], ZERO_EXP);
    chk("b2b block 2", out_val[2], subst(ED_IN, 1'b0));
    drain(20);

    // reset mid-block
    in_valid = 1'b1;
    state_in = VEC;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 128'(out_valid_w), 128'(0));
    chk("mid reset in_ready", 128'(in_ready_w), 128'(5'h1f));
    chk("mid reset busy", 128'(busy_w), 128'(0));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("no pulse after reset", 128'(out_valid_w), 128'(0));
    end
    run_block(VEC, 1'b0, VEC_EXP);
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
